// File: rtl/disp_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment scanner.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low.
package disp_pkg;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_GFX = 1'b1
  } disp_mode_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] sel_of(logic [2:0] i);
    return ~(8'h01 << i);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern, dp off.
module hex7seg_decode
  import disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/disp_scan_ctrl.sv
// 8-digit 7-segment scan controller with per-frame payload shadowing.
// Optional ghost blanking of digit enables: define DISP_GHOST_BLANK_EN.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] i_data,
  input  logic        disp_mode,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
`ifdef DISP_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    nxt_idx;
  logic          started;
  logic [63:0]   sh_data;
  disp_mode_e    sh_mode;
  logic [63:0]   data_sel;
  disp_mode_e    mode_sel;
  logic          tick;
  logic          frame_start;
  logic [3:0]    nib;
  logic [7:0]    hex_seg;
  logic [7:0]    seg_nxt;

  // First tick after reset is a frame start regardless of idx.
  always_comb begin
    tick        = (cnt == LAST);
    frame_start = tick && (!started || idx == 3'd7);
    nxt_idx     = frame_start ? 3'd0 : idx + 3'd1;
    data_sel    = frame_start ? i_data : sh_data;
    mode_sel    = frame_start ? disp_mode_e'(disp_mode) : sh_mode;
    nib         = data_sel[{nxt_idx, 2'b00} +: 4];
    seg_nxt     = hex_seg;
    if (mode_sel == MODE_GFX)
      seg_nxt = data_sel[{nxt_idx, 3'b000} +: 8];
  end

  hex7seg_decode u_dec (
    .digit (nib),
    .seg   (hex_seg)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      idx     <= 3'd0;
      started <= 1'b0;
      sh_data <= '0;
      sh_mode <= MODE_HEX;
      o_seg   <= SEG_OFF;
      o_sel   <= SEG_OFF;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        started <= 1'b1;
        idx     <= nxt_idx;
        o_seg   <= seg_nxt;
        o_sel   <= GHOST ? SEG_OFF : sel_of(nxt_idx);
        if (frame_start) begin
          sh_data <= i_data;
          sh_mode <= disp_mode_e'(disp_mode);
        end
      end else if (GHOST && started && cnt == BLANK_LAST) begin
        o_sel <= sel_of(idx);
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// Honours DISP_GHOST_BLANK_EN when the build defines it.
module tb_disp_scan_ctrl;

  localparam int DIV = 8;
  localparam int BLK = 2;
`ifdef DISP_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] i_data = 64'h0000_0000_8765_4321;
  logic        disp_mode = 1'b0;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;

  int n_cmp = 0;
  int n_bad = 0;

  disp_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_data    (i_data),
    .disp_mode (disp_mode),
    .o_seg     (o_seg),
    .o_sel     (o_sel)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Model: e counts clock edges since reset release. A slot lasts DIV
  // edges; slot s (1-based) starts at edge DIV*s and shows digit (s-1)%8.
  int          e = 0;
  logic [63:0] cap_d = '0;
  logic        cap_m = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e     = 0;
      cap_d = '0;
      cap_m = 1'b0;
    end else begin
      e = e + 1;
      if (e % DIV == 0 && ((e / DIV - 1) % 8) == 0) begin
        cap_d = i_data;
        cap_m = disp_mode;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] xs;
    logic [7:0] xl;
    int         s;
    int         d;
    int         off;
    logic       ok;
    xs = 8'hFF;
    xl = 8'hFF;
    if (rstn && e >= DIV) begin
      s   = e / DIV;
      d   = (s - 1) % 8;
      off = e % DIV;
      xs  = cap_m ? cap_d[8*d +: 8] : hex_tab[cap_d[4*d +: 4]];
      xl  = (GHOST && off < BLK) ? 8'hFF : ~(8'h01 << d);
    end
    chk("model_seg", o_seg, xs);
    chk("model_sel", o_sel, xl);
    ok = (o_sel == 8'hFF) || ($countones(~o_sel) == 1);
    chk("sel_onehot", {7'd0, ok}, 8'd1);
  end

  function automatic int at(input int f, input int d, input int o);
    return DIV * (8 * f + d + 1) + o;
  endfunction

  task automatic go(input int tgt);
    int n;
    n = 0;
    @(negedge clk);
    while (e != tgt && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (e != tgt) begin
      n_bad++;
      n_cmp++;
      $display("FAIL wait_e: got %0d want %0d", e, tgt);
    end
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_seg", o_seg, 8'hFF);
    chk("rst_sel", o_sel, 8'hFF);
    #1 rstn = 1'b1;

    go(DIV - 1);
    chk("pre_tick_seg", o_seg, 8'hFF);
    chk("pre_tick_sel", o_sel, 8'hFF);
    go(at(0, 0, 0));
    chk("d0_blank_sel", o_sel, GHOST ? 8'hFF : 8'hFE);
    chk("d0_off0_seg", o_seg, 8'hF9);
    go(at(0, 0, 4));
    chk("hex_d0_seg", o_seg, 8'hF9);
    chk("hex_d0_sel", o_sel, 8'hFE);
    go(at(0, 3, 4));
    chk("hex_d3_seg", o_seg, 8'h99);
    chk("hex_d3_sel", o_sel, 8'hF7);
    #1;
    i_data    = 64'hC6F6F6F0C6F6F6F0;
    disp_mode = 1'b1;
    go(at(0, 4, 4));
    chk("old_d4_seg", o_seg, 8'h92);
    go(at(0, 7, 4));
    chk("hex_d7_seg", o_seg, 8'h80);
    chk("hex_d7_sel", o_sel, 8'h7F);

    go(at(1, 0, 4));
    chk("gfx_d0_seg", o_seg, 8'hF0);
    go(at(1, 1, 4));
    chk("gfx_d1_seg", o_seg, 8'hF6);
    go(at(1, 3, 4));
    chk("gfx_d3_seg", o_seg, 8'hC6);
    go(at(1, 5, 4));
    #1;
    i_data    = 64'hFFFF_FFFF_0FED_CBA9;
    disp_mode = 1'b0;
    go(at(1, 7, 4));
    chk("gfx_d7_seg", o_seg, 8'hC6);
    chk("gfx_d7_sel", o_sel, 8'h7F);

    go(at(2, 0, 4));
    chk("f2_d0_seg", o_seg, 8'h90);
    go(at(2, 1, 4));
    chk("f2_d1_seg", o_seg, 8'h88);
    go(at(2, 5, 3));
    chk("f2_d5_seg", o_seg, 8'h86);
    chk("f2_d5_sel", o_sel, 8'hDF);
    #1 rstn = 1'b0;
    #1;
    chk("async_seg", o_seg, 8'hFF);
    chk("async_sel", o_sel, 8'hFF);
    i_data = 64'h0000_0000_1234_5678;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    go(DIV - 1);
    chk("post_rst_seg", o_seg, 8'hFF);
    chk("post_rst_sel", o_sel, 8'hFF);
    go(at(0, 0, 4));
    chk("post_rst_d0_seg", o_seg, 8'h80);
    chk("post_rst_d0_sel", o_sel, 8'hFE);
    go(at(1, 2, 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (legal range 4 to 2^24).
REQ-002 SHALL have parameter BLANK_CYC, default 500, meaning dead cycles at the start of each slot (legal range 1 to SCAN_DIV-2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_data, input, 64 bits: display payload.
REQ-006 SHALL have port disp_mode, input, 1 bit: 0 selects hex mode, 1 selects raw-segment (graphics) mode.
REQ-007 SHALL have port o_seg, output, 8 bits: active-low segment lines {dp,g,f,e,d,c,b,a}.
REQ-008 SHALL have port o_sel, output, 8 bits: active-low digit enables; bit 0 is the rightmost digit.

Function
REQ-009 SHALL count clk cycles from 0 to SCAN_DIV-1 with a slot counter, then wrap to 0; the wrap cycle is the tick.
REQ-010 SHALL advance the 3-bit digit index on each tick, 7 wraps to 0.
REQ-011 SHALL load i_data and disp_mode into shadow registers only on the tick that moves the index from 7 to 0 (frame start), so a frame never mixes two payloads.
REQ-012 SHALL treat the first tick after reset as a frame start: load the shadows and drive digit 0.
REQ-013 SHALL, in hex mode, decode digit n from shadow bits [4n+3:4n] using the fixed table 0-F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E, with dp off (bit 7 = 1); shadow bits [63:32] are ignored.
REQ-014 SHALL, in graphics mode, drive digit n with shadow bits [8n+7:8n] unmodified.
REQ-015 SHALL register o_seg and o_sel; the outputs reflect the new digit on the cycle after the tick.
REQ-016 SHALL drive o_sel as ~(1<<index) outside the blanking window, with exactly one bit low.
REQ-017 SHALL treat changes to i_data and disp_mode between frame starts as invisible until the next frame start.

Reset
REQ-018 SHALL, while rstn is low, hold o_seg=8'hFF, o_sel=8'hFF, slot counter 0, index 0, shadow data 0, shadow mode 0.
REQ-019 SHALL keep o_seg=8'hFF and o_sel=8'hFF after rstn deasserts until the first tick.
REQ-020 SHALL, on reset asserted mid-frame, blank both outputs asynchronously; the next frame restarts at digit 0 per REQ-012.

Configuration
REQ-021 SHALL implement ghost blanking under macro DISP_GHOST_BLANK_EN.
REQ-022 SHALL, when DISP_GHOST_BLANK_EN is defined, force o_sel=8'hFF for the first BLANK_CYC cycles after each tick while o_seg already carries the new pattern.
REQ-023 SHALL, when DISP_GHOST_BLANK_EN is undefined, ignore BLANK_CYC and switch o_sel directly on the cycle after the tick.

Structure
REQ-024 SHALL place the hex segment table, the all-off constant 8'hFF and the mode encodings in shared package disp_pkg.
REQ-025 SHALL implement hex decode in one combinational sub-module, hex7seg_decode: 4-bit in, 8-bit active-low out.
REQ-026 SHALL keep counters, shadows and output registers in disp_scan_ctrl.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-027 SHALL cover hex frame: i_data=64'h0000_0000_8765_4321, mode 0 -> digit 0 shows F9 with o_sel FE, digit 3 shows 99 with o_sel F7, digit 7 shows 80 with o_sel 7F; each digit held 8 cycles.
REQ-028 SHALL cover graphics frame: i_data=64'hC6F6F6F0C6F6F6F0, mode 1 -> digit 0 o_seg F0, digit 1 F6, digit 3 C6, digit 7 C6.
REQ-029 SHALL cover mid-frame change: change i_data while index is 3 -> digits 4-7 still show the old value; the new value appears from the next digit 0.
REQ-030 SHALL cover reset: assert rstn during digit 5 -> o_seg and o_sel are FF in the same cycle; after release they stay FF for 8 cycles, then digit 0 shows the current input.
REQ-031 SHALL cover blanking: with DISP_GHOST_BLANK_EN defined -> o_sel=FF for 2 cycles after each tick, then one-hot low for 6 cycles; with it undefined -> one-hot low for all 8 cycles.
REQ-032 SHALL cover a continuous run: over 3 frames, o_sel always has exactly one bit low or all bits high, and the digit order is 0..7 with wrap.
